dispatch_demux_4: RTL and testbench
===================================

// Module: dispatch_demux_4
// PURPOSE
//  1-to-4 routing demultiplexer with per-lane buffering; the distribution counterpart of the select muxes.
//  Accepts one 32-bit word per cycle from an upstream stage with a 2-bit lane select.
//  Queues the word in the selected lane's FIFO for that downstream consumer (e.g. ALU/MUL/DIV/LSU issue slots).
//  Valid/ready handshake on every port; lanes drain independently, so a stalled lane never blocks the others.
// PARAMETERS
//  W      32  data width in bits
//  DEPTH  2   entries per lane FIFO; power of two, >= 2
//  AW     1   log2(DEPTH); pointer width; count width is AW+1
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        synchronous reset, active high
//  flush      in   1        synchronous clear of all lanes (pipeline flush)
//  in_valid   in   1        upstream word present
//  in_sel     in   2        destination lane 0..3
//  in_data    in   W        word to route
//  in_ready   out  1        selected lane can accept this cycle
//  out_valid  out  4        bit k: lane k head valid
//  out_ready  in   4        bit k: consumer k takes the head this cycle
//  out_data   out  4*W      lane k head at [k*W +: W]
//  lane_cnt   out  4*(AW+1) lane k occupancy at [k*(AW+1) +: AW+1]
// BEHAVIOUR
//  - Reset: on the clk edge with rst=1, all counts, pointers and storage go to 0.
//    out_valid=0, out_data=0, lane_cnt=0. in_ready=0 while rst=1.
//  - Push: push_k = in_valid & in_ready & (in_sel==k).
//  - Pop: pop_k = out_valid[k] & out_ready[k].
//  - in_ready = ~rst & ~flush & (cnt[in_sel] != DEPTH). It is combinational from in_sel.
//    in_ready never depends on out_ready: no ready-to-ready path.
//  - Upstream holds in_sel and in_data stable while in_valid & ~in_ready.
//  - Latency: a word pushed at edge N is visible on out_valid/out_data after edge N. There is no same-cycle bypass.
//  - out_valid[k] = (cnt_k != 0). out_data lane k = mem_k[rd_ptr_k]. Both are registered-state outputs.
//  - Per-lane count update:
//    push only: +1
//    pop only: -1
//    push and pop together: unchanged; write at wr_ptr, read from rd_ptr, both pointers advance.
//    Pointers wrap modulo DEPTH.
//  - Full lane (cnt=DEPTH): in_ready=0 for that sel, even if the lane pops in the same cycle. Other lanes still accept.
//  - Empty lane: out_ready is ignored. There is no underflow; the count stays 0.
//  - Ordering: words to the same lane leave in arrival order. There is no ordering guarantee across lanes.
//  - flush=1: at the edge, all counts and pointers go to 0. Any push or pop in that cycle is discarded.
//    out_valid=0 from the next cycle. Storage contents need not be cleared.
//  - Priority: rst > flush > push/pop.
//  - Reset or flush mid-stream loses all queued words. That is expected behaviour, not an error.
//  - No combinational loops. All state updates on posedge clk only.
// TESTING
//  1. Reset: assert rst 2 cycles with in_valid=1 -> in_ready=0, out_valid=4'b0000, lane_cnt all 0, out_data=0.
//  2. Route: push 0xA0 sel0, 0xB1 sel1, 0xC2 sel2, 0xD3 sel3 on consecutive cycles, out_ready=4'hF ->
//     each lane shows its word exactly 1 cycle after its push; out_valid pulses 1 cycle per lane.
//  3. Fill and backpressure: out_ready[2]=0; push 0x11, 0x22, 0x33 to sel2 ->
//     first two accepted, lane_cnt2=2, in_ready=0 on the third.
//     Then sel0 push of 0x44 is accepted in the same stall period.
//  4. Full with pop: lane2 full, out_ready[2]=1 with sel2 push pending ->
//     no accept that cycle; accept the next cycle.
//     Drain order is 0x11, 0x22, 0x33.
//  5. Steady state: lane1 cnt=1, push and pop every cycle for 8 cycles with data 1..8 ->
//     cnt stays 1, outputs in order, pointers wrap with no loss.
//  6. Flush: lanes hold 1/2/0/1 words; flush=1 with a simultaneous push and pop ->
//     next cycle all lane_cnt=0 and out_valid=0. The flush-cycle push is absent afterwards.

Source files
------------

// File: rtl/dispatch_demux_4.sv
// 1-to-4 routing demultiplexer: each upstream word is queued in the FIFO of its selected lane,
// and the four lanes drain independently through their own valid/ready handshakes.
module dispatch_demux_4 #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  input  logic [1:0]          in_sel,
  input  logic [W-1:0]        in_data,
  output logic                in_ready,
  output logic [3:0]          out_valid,
  input  logic [3:0]          out_ready,
  output logic [4*W-1:0]      out_data,
  output logic [4*(AW+1)-1:0] lane_cnt
);

  localparam int unsigned LANES = 4;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem    [LANES][DEPTH];
  logic [AW-1:0] wr_ptr [LANES];
  logic [AW-1:0] rd_ptr [LANES];
  logic [AW:0]   cnt    [LANES];
  logic [3:0]    push;
  logic [3:0]    pop;

  // Acceptance depends only on the selected lane's occupancy, never on out_ready.
  always_comb begin
    in_ready = ~rst & ~flush & (cnt[in_sel] != FULL);
  end

  always_comb begin
    push = '0;
    pop  = '0;
    for (int k = 0; k < LANES; k++) begin
      push[k] = in_valid & in_ready & (in_sel == 2'(k));
      pop[k]  = out_valid[k] & out_ready[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LANES; k++) begin
        for (int d = 0; d < DEPTH; d++) begin
          mem[k][d] <= '0;
        end
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        cnt[k]    <= '0;
      end
    end else if (flush) begin
      // Storage is left as is; only occupancy state is discarded.
      for (int k = 0; k < LANES; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        cnt[k]    <= '0;
      end
    end else begin
      for (int k = 0; k < LANES; k++) begin
        if (push[k]) begin
          mem[k][wr_ptr[k]] <= in_data;
          wr_ptr[k]         <= wr_ptr[k] + AW'(1);
        end
        if (pop[k]) begin
          rd_ptr[k] <= rd_ptr[k] + AW'(1);
        end
        if (push[k] && !pop[k]) begin
          cnt[k] <= cnt[k] + (AW+1)'(1);
        end else if (pop[k] && !push[k]) begin
          cnt[k] <= cnt[k] - (AW+1)'(1);
        end
      end
    end
  end

  // Heads and occupancies are decoded straight from registered state.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign out_valid[g]                   = (cnt[g] != '0);
    assign out_data[g*W +: W]             = mem[g][rd_ptr[g]];
    assign lane_cnt[g*(AW+1) +: (AW+1)]   = cnt[g];
  end

endmodule

// File: tb/tb_dispatch_demux_4.sv
// Directed bench for dispatch_demux_4: a vector table for routing/backpressure,
// plus hand-written sequences for steady-state wrap and flush.
module tb_dispatch_demux_4;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic [1:0]   in_sel;
  logic [31:0]  in_data;
  logic         in_ready;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [127:0] out_data;
  logic [7:0]   lane_cnt;

  int checks = 0;
  int errors = 0;

  dispatch_demux_4 #(.W(32), .DEPTH(2), .AW(1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_sel(in_sel), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .lane_cnt(lane_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [1:0]  sel;
    logic [31:0] d;
    logic [3:0]  ordy;
    logic        e_rdy;
    logic [3:0]  e_ov;
    logic [7:0]  e_cnt;
    logic [1:0]  e_lane;
    logic [31:0] e_dat;
  } vec_t;

  vec_t tv [12];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] sel, input logic [31:0] d,
                       input logic [3:0] ordy, input logic fl);
    in_valid  = v;
    in_sel    = sel;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // cycle:                v   sel  data     ordy   rdy  ov       cnt    lane dat
    tv[0]  = '{1'b1, 2'd0, 32'hA0, 4'hF,    1'b1, 4'b0001, 8'h01, 2'd0, 32'hA0};
    tv[1]  = '{1'b1, 2'd1, 32'hB1, 4'hF,    1'b1, 4'b0010, 8'h04, 2'd1, 32'hB1};
    tv[2]  = '{1'b1, 2'd2, 32'hC2, 4'hF,    1'b1, 4'b0100, 8'h10, 2'd2, 32'hC2};
    tv[3]  = '{1'b1, 2'd3, 32'hD3, 4'hF,    1'b1, 4'b1000, 8'h40, 2'd3, 32'hD3};
    tv[4]  = '{1'b0, 2'd0, 32'h0,  4'hF,    1'b1, 4'b0000, 8'h00, 2'd0, 32'h0};
    tv[5]  = '{1'b1, 2'd2, 32'h11, 4'b1011, 1'b1, 4'b0100, 8'h10, 2'd2, 32'h11};
    tv[6]  = '{1'b1, 2'd2, 32'h22, 4'b1011, 1'b1, 4'b0100, 8'h20, 2'd2, 32'h11};
    tv[7]  = '{1'b1, 2'd2, 32'h33, 4'b1011, 1'b0, 4'b0100, 8'h20, 2'd2, 32'h11};
    tv[8]  = '{1'b1, 2'd0, 32'h44, 4'b1011, 1'b1, 4'b0101, 8'h21, 2'd0, 32'h44};
    tv[9]  = '{1'b1, 2'd2, 32'h33, 4'hF,    1'b0, 4'b0100, 8'h10, 2'd2, 32'h22};
    tv[10] = '{1'b1, 2'd2, 32'h33, 4'hF,    1'b1, 4'b0100, 8'h10, 2'd2, 32'h33};
    tv[11] = '{1'b0, 2'd2, 32'h0,  4'hF,    1'b1, 4'b0000, 8'h00, 2'd2, 32'h0};

    // Reset held two cycles with a word offered.
    rst = 1'b1;
    drive(1'b1, 2'd1, 32'hDEAD, 4'hF, 1'b0);
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'(1'b0));
    repeat (2) tick();
    chk("rst_in_ready_held", 128'(in_ready), 128'(1'b0));
    chk("rst_out_valid", 128'(out_valid), 128'(4'b0000));
    chk("rst_lane_cnt", 128'(lane_cnt), 128'(8'h00));
    chk("rst_out_data", out_data, 128'(0));
    rst = 1'b0;

    // Routing, fill/backpressure and full-with-pop vectors.
    for (int i = 0; i < 12; i++) begin
      drive(tv[i].v, tv[i].sel, tv[i].d, tv[i].ordy, 1'b0);
      #1;
      chk($sformatf("vec%0d_in_ready", i), 128'(in_ready), 128'(tv[i].e_rdy));
      tick();
      chk($sformatf("vec%0d_out_valid", i), 128'(out_valid), 128'(tv[i].e_ov));
      chk($sformatf("vec%0d_lane_cnt", i), 128'(lane_cnt), 128'(tv[i].e_cnt));
      if (tv[i].e_ov[tv[i].e_lane])
        chk($sformatf("vec%0d_out_data", i), 128'(out_data[tv[i].e_lane*32 +: 32]),
            128'(tv[i].e_dat));
    end

    // Steady state on lane 1: one word resident, push and pop every cycle.
    drive(1'b1, 2'd1, 32'h0, 4'h0, 1'b0);
    tick();
    chk("ss_prime_cnt", 128'(lane_cnt), 128'(8'h04));
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 2'd1, 32'(i), 4'b0010, 1'b0);
      #1;
      chk($sformatf("ss%0d_in_ready", i), 128'(in_ready), 128'(1'b1));
      tick();
      chk($sformatf("ss%0d_lane_cnt", i), 128'(lane_cnt), 128'(8'h04));
      chk($sformatf("ss%0d_head", i), 128'(out_data[63:32]), 128'(32'(i)));
    end
    drive(1'b0, 2'd1, 32'h0, 4'b0010, 1'b0);
    tick();
    chk("ss_drain_cnt", 128'(lane_cnt), 128'(8'h00));

    // Flush with lanes holding 1/2/0/1 words and a simultaneous push and pop.
    drive(1'b1, 2'd0, 32'h50, 4'h0, 1'b0); tick();
    drive(1'b1, 2'd1, 32'h61, 4'h0, 1'b0); tick();
    drive(1'b1, 2'd1, 32'h62, 4'h0, 1'b0); tick();
    drive(1'b1, 2'd3, 32'h73, 4'h0, 1'b0); tick();
    chk("fl_pre_cnt", 128'(lane_cnt), 128'(8'h49));
    chk("fl_pre_valid", 128'(out_valid), 128'(4'b1011));
    drive(1'b1, 2'd2, 32'hEE, 4'hF, 1'b1);
    #1;
    chk("fl_in_ready", 128'(in_ready), 128'(1'b0));
    tick();
    chk("fl_post_cnt", 128'(lane_cnt), 128'(8'h00));
    chk("fl_post_valid", 128'(out_valid), 128'(4'b0000));
    drive(1'b0, 2'd2, 32'h0, 4'h0, 1'b0);
    #1;
    chk("fl_ready_after", 128'(in_ready), 128'(1'b1));
    tick();
    chk("fl_push_absent", 128'(out_valid), 128'(4'b0000));

    // Queued words are simply dropped by a mid-stream reset.
    drive(1'b1, 2'd3, 32'h99, 4'h0, 1'b0); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_cnt", 128'(lane_cnt), 128'(8'h00));
    chk("rst2_data", out_data, 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
